extio8x4_axis_target: RTL

Target (responder) end of the extio8x4 link: 8-bit transfers over a 4-bit bidirectional data plane, with request pins ioreq1/ioreq2 driven by the initiator and an ack pin driven back by this block.
- Synchronizes the asynchronous pad inputs and decodes the initiator's phase sequence.
- Pushes write bytes onto two AXIS master channels (tx0/tx1).
- Sources read bytes from two AXIS slave channels (rx0/rx1).
- Sits in the pad-facing I/O subsystem of the target chip.

---
 rtl/extio8x4_pkg.sv | 25 ++
 rtl/extio8x4_tfsm.sv | 180 ++++++++++++++++++
 rtl/extio8x4_axis_target.sv | 134 +++++++++++++
 3 files changed

// File: rtl/extio8x4_pkg.sv
// rtl/extio8x4_pkg.sv - extio8x4 phase codes, command bit positions and FSM state encoding
package extio8x4_pkg;

    localparam logic [1:0] PH_IDLE = 2'b00;
    localparam logic [1:0] PH_CMD  = 2'b10;
    localparam logic [1:0] PH_HI   = 2'b11;
    localparam logic [1:0] PH_LO   = 2'b01;

    localparam int CMD_WR_BIT = 1;
    localparam int CMD_CH_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD_WAIT,
        ST_CMD_ACK,
        ST_WR_HI,
        ST_WR_LO,
        ST_RD_HI_SET,
        ST_RD_HI,
        ST_RD_LO_SET,
        ST_RD_LO,
        ST_END
    } state_t;

endpackage

// File: rtl/extio8x4_tfsm.sv
// rtl/extio8x4_tfsm.sv - extio8x4 target protocol FSM operating on synchronized pad inputs
module extio8x4_tfsm
    import extio8x4_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ph,
    input  logic [3:0] data_s,
    input  logic [1:0] tx_full,
    input  logic [1:0] rx_tvalid,
    input  logic [7:0] rx_tdata0,
    input  logic [7:0] rx_tdata1,
    output logic [1:0] rx_tready,
    output logic       tx_push,
    output logic       tx_ch,
    output logic [7:0] tx_byte,
    output logic       ack,
    output logic       oe,
    output logic [3:0] dout
);

    state_t     state_q, state_d;
    logic [1:0] ph_q;
    logic       is_wr_q, is_wr_d;
    logic       ch_q, ch_d;
    logic [7:0] byte_q, byte_d;
    logic       ack_q, ack_d;
    logic       oe_q, oe_d;
    logic [3:0] dout_q, dout_d;
    logic       ph_chg;
    logic       proto_err;

    assign ph_chg  = (ph != ph_q);
    assign tx_ch   = ch_q;
    assign tx_byte = {byte_q[7:4], data_s};
    assign ack     = ack_q;
    assign oe      = oe_q;
    assign dout    = dout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ph_q    <= PH_IDLE;
            is_wr_q <= 1'b0;
            ch_q    <= 1'b0;
            byte_q  <= '0;
            ack_q   <= 1'b0;
            oe_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph;
            is_wr_q <= is_wr_d;
            ch_q    <= ch_d;
            byte_q  <= byte_d;
            ack_q   <= ack_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
        end
    end

    // Every waiting state treats any phase change other than the single expected one as an error.
    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        ch_d      = ch_q;
        byte_d    = byte_q;
        ack_d     = ack_q;
        oe_d      = oe_q;
        dout_d    = dout_q;
        rx_tready = '0;
        tx_push   = 1'b0;
        proto_err = 1'b0;

        case (state_q)
            ST_IDLE, ST_END: begin
                if (state_q == ST_END) state_d = ST_IDLE;
                if (ph_chg) begin
                    if (ph == PH_CMD) begin
                        is_wr_d = data_s[CMD_WR_BIT];
                        ch_d    = data_s[CMD_CH_BIT];
                        state_d = ST_CMD_WAIT;
                    end else begin
                        proto_err = 1'b1;
                    end
                end
            end
            ST_CMD_WAIT: begin
                if (ph_chg) begin
                    proto_err = 1'b1;
                end else if (is_wr_q) begin
                    if (!tx_full[ch_q]) begin
                        ack_d   = 1'b1;
                        state_d = ST_CMD_ACK;
                    end
                end else if (rx_tvalid[ch_q]) begin
                    rx_tready[ch_q] = 1'b1;
                    byte_d  = ch_q ? rx_tdata1 : rx_tdata0;
                    ack_d   = 1'b1;
                    state_d = ST_CMD_ACK;
                end
            end
            ST_CMD_ACK: begin
                if (ph_chg) begin
                    if (ph != PH_HI) begin
                        proto_err = 1'b1;
                    end else if (is_wr_q) begin
                        byte_d[7:4] = data_s;
                        ack_d       = 1'b0;
                        state_d     = ST_WR_HI;
                    end else begin
                        oe_d    = 1'b1;
                        dout_d  = byte_q[7:4];
                        state_d = ST_RD_HI_SET;
                    end
                end
            end
            ST_WR_HI: begin
                if (ph_chg) begin
                    if (ph == PH_LO) begin
                        tx_push = 1'b1;
                        ack_d   = 1'b1;
                        state_d = ST_WR_LO;
                    end else begin
                        proto_err = 1'b1;
                    end
                end
            end
            ST_WR_LO, ST_RD_LO: begin
                if (ph_chg) begin
                    if (ph == PH_IDLE) begin
                        ack_d   = 1'b0;
                        oe_d    = 1'b0;
                        dout_d  = '0;
                        state_d = ST_END;
                    end else begin
                        proto_err = 1'b1;
                    end
                end
            end
            ST_RD_HI_SET: begin
                if (ph_chg) begin
                    proto_err = 1'b1;
                end else begin
                    ack_d   = 1'b0;
                    state_d = ST_RD_HI;
                end
            end
            ST_RD_HI: begin
                if (ph_chg) begin
                    if (ph == PH_LO) begin
                        dout_d  = byte_q[3:0];
                        state_d = ST_RD_LO_SET;
                    end else begin
                        proto_err = 1'b1;
                    end
                end
            end
            ST_RD_LO_SET: begin
                if (ph_chg) begin
                    proto_err = 1'b1;
                end else begin
                    ack_d   = 1'b1;
                    state_d = ST_RD_LO;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (proto_err) begin
            state_d   = ST_IDLE;
            ack_d     = 1'b0;
            oe_d      = 1'b0;
            dout_d    = '0;
            tx_push   = 1'b0;
            rx_tready = '0;
        end
    end

endmodule

// File: rtl/extio8x4_axis_target.sv
// rtl/extio8x4_axis_target.sv - extio8x4 target wrapper: pad synchronizers, tx buffering (EXTIO8X4_TXSKID_EN), FSM
module extio8x4_axis_target
    import extio8x4_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       testmode,
    input  logic       axis_tx0_tready,
    output logic       axis_tx0_tvalid,
    output logic [7:0] axis_tx0_tdata8,
    input  logic       axis_tx1_tready,
    output logic       axis_tx1_tvalid,
    output logic [7:0] axis_tx1_tdata8,
    output logic       axis_rx0_tready,
    input  logic       axis_rx0_tvalid,
    input  logic [7:0] axis_rx0_tdata8,
    output logic       axis_rx1_tready,
    input  logic       axis_rx1_tvalid,
    input  logic [7:0] axis_rx1_tdata8,
    input  logic [3:0] iodata4_a,
    output logic [3:0] iodata4_o,
    output logic [3:0] iodata4_e,
    output logic [3:0] iodata4_t,
    input  logic       ioreq1_a,
    input  logic       ioreq2_a,
    output logic       ioack_o
);

    // Request and data share one synchronizer chain so they stay cycle-aligned.
    logic [5:0] pad_raw, pad_s;
    logic [5:0] sync_q [SYNC_STAGES];

    assign pad_raw = {ioreq1_a, ioreq2_a, iodata4_a};
    assign pad_s   = testmode ? pad_raw : sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pad_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    logic [1:0] tx_full, tx_tvalid, tx_tready;
    logic [7:0] tx_tdata [2];
    logic [1:0] rx_tready;
    logic       tx_push, tx_ch, ack, oe;
    logic [7:0] tx_byte;
    logic [3:0] dout;

    assign tx_tready = {axis_tx1_tready, axis_tx0_tready};

    for (genvar g = 0; g < 2; g++) begin : g_tx
        logic push, pop;
        assign push = tx_push && (int'(tx_ch) == g);
        assign pop  = tx_tvalid[g] && tx_tready[g];
`ifdef EXTIO8X4_TXSKID_EN
        logic [7:0] mem [2];
        logic       rd_ptr, wr_ptr;
        logic [1:0] cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                cnt    <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= tx_byte;
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
                cnt <= cnt + {1'b0, push} - {1'b0, pop};
            end
        end

        assign tx_full[g]   = (cnt == 2'd2);
        assign tx_tvalid[g] = (cnt != 2'd0);
        assign tx_tdata[g]  = mem[rd_ptr];
`else
        logic       hold_valid;
        logic [7:0] hold_data;

        always_ff @(posedge clk) begin
            if (reset) begin
                hold_valid <= 1'b0;
                hold_data  <= '0;
            end else if (push) begin
                hold_valid <= 1'b1;
                hold_data  <= tx_byte;
            end else if (pop) begin
                hold_valid <= 1'b0;
            end
        end

        assign tx_full[g]   = hold_valid;
        assign tx_tvalid[g] = hold_valid;
        assign tx_tdata[g]  = hold_data;
`endif
    end

    extio8x4_tfsm u_fsm (
        .clk       (clk),
        .reset     (reset),
        .ph        (pad_s[5:4]),
        .data_s    (pad_s[3:0]),
        .tx_full   (tx_full),
        .rx_tvalid ({axis_rx1_tvalid, axis_rx0_tvalid}),
        .rx_tdata0 (axis_rx0_tdata8),
        .rx_tdata1 (axis_rx1_tdata8),
        .rx_tready (rx_tready),
        .tx_push   (tx_push),
        .tx_ch     (tx_ch),
        .tx_byte   (tx_byte),
        .ack       (ack),
        .oe        (oe),
        .dout      (dout)
    );

    assign axis_tx0_tvalid = tx_tvalid[0];
    assign axis_tx0_tdata8 = tx_tdata[0];
    assign axis_tx1_tvalid = tx_tvalid[1];
    assign axis_tx1_tdata8 = tx_tdata[1];
    assign axis_rx0_tready = rx_tready[0];
    assign axis_rx1_tready = rx_tready[1];
    assign iodata4_o       = dout;
    assign iodata4_e       = {4{oe}};
    assign iodata4_t       = ~iodata4_e;
    assign ioack_o         = ack;

endmodule
